// File: rtl/fir_peak_detector.sv
// Peak-magnitude detector for framed FIR output.
// Tracks the largest |sample| and its index, then reports it against a threshold.
module fir_peak_detector #(
    parameter int DATA_WIDTH   = 19,
    parameter int FRAME_LENGTH = 52,
    parameter int INDEX_WIDTH  = 6
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic                          startFlag,
    input  logic                          dataInValid,
    input  logic signed [DATA_WIDTH-1:0]  dataIn,
    input  logic        [DATA_WIDTH-1:0]  threshold,
    output logic        [DATA_WIDTH-1:0]  peakValue,
    output logic        [INDEX_WIDTH-1:0] peakIndex,
    output logic                          peakValid,
    output logic                          detectFlag,
    output logic                          busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_REPORT  = 2'd2
    } state_t;

    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(FRAME_LENGTH - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0]  MAG_ONE  = DATA_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [INDEX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   peak_value_q, peak_value_d;
    logic [INDEX_WIDTH-1:0]  peak_index_q, peak_index_d;
    logic                    detect_q, detect_d;

    logic                    sample_take;
    logic                    last_sample;
    logic                    take_new;
    logic [DATA_WIDTH-1:0]   sample_mag;
    logic                    over_thr;

    // Two's-complement negate in unsigned space: the most negative code maps
    // to 2^(DATA_WIDTH-1), which still fits the unsigned width.
    function automatic logic [DATA_WIDTH-1:0] magnitude(input logic signed [DATA_WIDTH-1:0] s);
        logic [DATA_WIDTH-1:0] u;
        u = $unsigned(s);
        if (s[DATA_WIDTH-1]) begin
            magnitude = ~u + MAG_ONE;
        end else begin
            magnitude = u;
        end
    endfunction

    // Running-max datapath
    always_comb begin
        sample_take = (state_q == S_COLLECT) && dataInValid;
        last_sample = (cnt_q == LAST_IDX);
        sample_mag  = magnitude(dataIn);
        take_new    = (cnt_q == '0) || (sample_mag > max_q);
        max_d       = take_new ? sample_mag : max_q;
        idx_d       = take_new ? cnt_q : idx_q;
        over_thr    = (peak_value_q >= threshold);
    end

    // State register
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (startFlag) begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (sample_take && last_sample) begin
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Counter and reported-result next state
    always_comb begin
        cnt_d        = cnt_q;
        peak_value_d = peak_value_q;
        peak_index_d = peak_index_q;
        detect_d     = detect_q;
        if ((state_q == S_IDLE) && startFlag) begin
            cnt_d = '0;
        end else if (sample_take) begin
            if (last_sample) begin
                cnt_d        = '0;
                peak_value_d = max_d;
                peak_index_d = idx_d;
            end else begin
                cnt_d = cnt_q + IDX_ONE;
            end
        end
        if (state_q == S_REPORT) begin
            detect_d = over_thr;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            cnt_q        <= '0;
            peak_value_q <= '0;
            peak_index_q <= '0;
            detect_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            peak_value_q <= peak_value_d;
            peak_index_q <= peak_index_d;
            detect_q     <= detect_d;
        end
    end

    // Running max is always reloaded by the first sample, so it needs no reset
    always_ff @(posedge clock) begin
        if ((state_q == S_IDLE) && startFlag) begin
            max_q <= '0;
            idx_q <= '0;
        end else if (sample_take) begin
            max_q <= max_d;
            idx_q <= idx_d;
        end
    end

    // Output logic
    always_comb begin
        peakValid  = (state_q == S_REPORT);
        busy       = (state_q != S_IDLE);
        detectFlag = (state_q == S_REPORT) ? over_thr : detect_q;
        peakValue  = peak_value_q;
        peakIndex  = peak_index_q;
    end

endmodule

// File: doc/fir_peak_detector.md
FIR_PEAK_DETECTOR -- requirements
Module: fir_peak_detector

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 19, the signed sample width, matching the n_tap_fir dataOut width.
REQ-002 The block SHALL have parameter FRAME_LENGTH, default 52, the samples per frame (33 data + 20 taps - 1).
REQ-003 The block SHALL have parameter INDEX_WIDTH, default 6, the peak index width; FRAME_LENGTH <= 2^INDEX_WIDTH.
REQ-004 The block SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port resetN, input, 1, the synchronous active-low reset.
REQ-006 The block SHALL have port startFlag, input, 1, which arms frame collection (level-sampled each clock).
REQ-007 The block SHALL have port dataInValid, input, 1, which qualifies dataIn.
REQ-008 The block SHALL have port dataIn, input, DATA_WIDTH, signed FIR output sample.
REQ-009 The block SHALL have port threshold, input, DATA_WIDTH, the unsigned detection threshold, sampled in REPORT.
REQ-010 The block SHALL have port peakValue, output, DATA_WIDTH, the unsigned magnitude of the largest sample in the frame.
REQ-011 The block SHALL have port peakIndex, output, INDEX_WIDTH, the 0-based position of that sample.
REQ-012 The block SHALL have port peakValid, output, 1, a one-cycle result strobe.
REQ-013 The block SHALL have port detectFlag, output, 1, set when peakValue >= threshold; valid with peakValid.
REQ-014 The block SHALL have port busy, output, 1, high while in COLLECT or REPORT.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, COLLECT and REPORT.
REQ-016 IDLE SHALL go to COLLECT on startFlag=1, clearing the sample counter, the running max and the index; all other inputs are ignored in IDLE.
REQ-017 In COLLECT, each cycle with dataInValid=1 SHALL consume one sample; cycles with dataInValid=0 SHALL hold all state.
REQ-018 Magnitude SHALL be |dataIn| as DATA_WIDTH-bit unsigned; -2^(DATA_WIDTH-1) SHALL map to 2^(DATA_WIDTH-1) exactly, with no saturation or wrap.
REQ-019 The first sample of a frame SHALL always load the running max, with index 0.
REQ-020 A later sample SHALL replace the max only if its magnitude is strictly greater, so that on ties the earliest index wins.
REQ-021 COLLECT SHALL go to REPORT on the clock that consumes sample FRAME_LENGTH-1; that final sample SHALL take part in the comparison.
REQ-022 REPORT SHALL last exactly one cycle: peakValid=1, peakValue and peakIndex hold the frame result, and detectFlag=(peakValue >= threshold). The next state SHALL be IDLE.
REQ-023 peakValid SHALL rise on the clock after the last sample is accepted (latency 1).
REQ-024 peakValue, peakIndex and detectFlag SHALL hold their last values until the next REPORT.
REQ-025 startFlag asserted during COLLECT or REPORT SHALL be ignored; a new frame needs startFlag in IDLE, so back-to-back frames lose at least one cycle.
REQ-026 The sample counter SHALL be INDEX_WIDTH bits wide and SHALL never exceed FRAME_LENGTH-1.
REQ-027 dataInValid asserted in IDLE or REPORT SHALL be discarded.

Reset
REQ-028 When resetN=0 at a rising clock edge, the state SHALL become IDLE, the counter 0, peakValue 0, peakIndex 0, and peakValid, detectFlag and busy 0.
REQ-029 Reset SHALL override every other input, including mid-COLLECT; the partial frame SHALL be discarded and no peakValid SHALL be issued.

Verification
REQ-030 Reset, start, then 52 valid samples all 0, threshold 1 -> peakValid once, on the cycle after sample 51; peakValue 0, peakIndex 0, detectFlag 0.
REQ-031 Frame of 52 samples with sample 20 = -1500, sample 30 = +1200, others within +/-100, threshold 1000 -> peakValue 1500, peakIndex 20, detectFlag 1.
REQ-032 Equal magnitudes +700 at index 5 and -700 at index 40, threshold 701 -> peakIndex 5, peakValue 700, detectFlag 0.
REQ-033 Sample 51 = -262144, others 0 -> peakValue 262144, peakIndex 51.
REQ-034 dataInValid toggling every other cycle across a 52-sample frame -> same result as the contiguous frame; peakValid 1 cycle after the 52nd valid sample; busy high throughout.
REQ-035 resetN=0 for 1 cycle after 30 samples, then startFlag and a full new frame -> no peakValid before the new frame completes; the result reflects only the new frame.
